// File: rtl/instr_boot_loader.sv
// ---------------------------------------------------------------------------
// instr_boot_loader
// Byte-serial boot controller. It parses the frame
//    START_TOK, N, N x (4-byte big-endian word), END_TOK
// writes each assembled word into instruction memory and then releases the
// CPU. The CPU is held idle during any load or reload. A framing fault is
// reported on a sticky error flag.
//
// Ports
//    clk_i          clock, rising edge
//    reset          asynchronous active-low reset
//    byte_valid_i   instr_i carries a byte this cycle
//    instr_i        stream byte
//    imem_we_o      imem write strobe, one cycle per word
//    imem_addr_o    imem word address
//    imem_wdata_o   assembled instruction word
//    cpu_run_o      1 = CPU may execute
//    load_done_o    one-cycle pulse on a clean frame end
//    load_err_o     sticky framing-error flag
//    instr_count_o  words written in the current or last frame
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for START_TOK; every other byte is ignored
// S_LEN     | next byte is the word count N (1..IMEM_DEPTH)
// S_PAYLOAD | assembling words; token values are plain data here
// S_END_CHK | next byte must be END_TOK
// S_RUN     | CPU released; START_TOK begins a reload
// S_ERR     | framing error; START_TOK begins a new load
// ---------------------------------------------------------------------------
module instr_boot_loader #(
   parameter int           INSTR_W    = 32,
   parameter int           IMEM_DEPTH = 64,
   parameter int           ADDR_W     = 6,
   parameter logic [7:0]   START_TOK  = 8'hFE,
   parameter logic [7:0]   END_TOK    = 8'hFF
) (
   input  logic                clk_i,
   input  logic                reset,
   input  logic                byte_valid_i,
   input  logic [7:0]          instr_i,
   output logic                imem_we_o,
   output logic [ADDR_W-1:0]   imem_addr_o,
   output logic [INSTR_W-1:0]  imem_wdata_o,
   output logic                cpu_run_o,
   output logic                load_done_o,
   output logic                load_err_o,
   output logic [ADDR_W:0]     instr_count_o
);

   localparam int         CW       = ADDR_W + 1;
   localparam logic [8:0] LP_DEPTH = 9'(IMEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_END_CHK,
      S_RUN,
      S_ERR
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_lane;
   logic [CW-1:0]        r_len;
   logic [CW-1:0]        r_count;
   logic [INSTR_W-9:0]   r_word;
   logic                 r_we;
   logic [ADDR_W-1:0]    r_addr;
   logic [INSTR_W-1:0]   r_wdata;
   logic                 r_done;
   logic                 r_err;

   logic                 w_is_start;
   logic                 w_is_end;
   logic                 w_len_ok;
   logic                 w_last_word;
   logic                 w_lane_last;

   assign w_is_start  = (instr_i == START_TOK);
   assign w_is_end    = (instr_i == END_TOK);
   assign w_len_ok    = (instr_i != 8'h00) && ({1'b0, instr_i} <= LP_DEPTH);
   assign w_lane_last = (r_lane == 2'd3);
   assign w_last_word = w_lane_last && ((r_count + CW'(1)) == r_len);

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (byte_valid_i && w_is_start) w_next = S_LEN;
         end
         S_LEN: begin
            if (byte_valid_i) w_next = w_len_ok ? S_PAYLOAD : S_ERR;
         end
         S_PAYLOAD: begin
            if (byte_valid_i && w_last_word) w_next = S_END_CHK;
         end
         S_END_CHK: begin
            if (byte_valid_i) w_next = w_is_end ? S_RUN : S_ERR;
         end
         S_RUN, S_ERR: begin
            if (byte_valid_i && w_is_start) w_next = S_LEN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath. The write strobe, address, data and the count increment all
   // land on the edge after the fourth byte, so the final write is visible
   // in the first cycle of S_END_CHK at the latest.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_lane  <= '0;
         r_len   <= '0;
         r_count <= '0;
         r_word  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= (r_state == S_END_CHK) && (w_next == S_RUN);
         // error is held exactly while parked in S_ERR; leaving it only
         // happens through S_LEN, which is what clears the flag
         r_err  <= (w_next == S_ERR);

         if ((r_state == S_LEN) && byte_valid_i && w_len_ok) begin
            r_len   <= CW'(instr_i);
            r_count <= '0;
            r_lane  <= '0;
         end

         if ((r_state == S_PAYLOAD) && byte_valid_i) begin
            r_lane <= r_lane + 2'd1;
            if (w_lane_last) begin
               r_we    <= 1'b1;
               r_wdata <= {r_word, instr_i};
               r_addr  <= r_count[ADDR_W-1:0];
               r_count <= r_count + CW'(1);
            end else begin
               r_word <= {r_word[INSTR_W-17:0], instr_i};
            end
         end
      end
   end

   assign imem_we_o     = r_we;
   assign imem_addr_o   = r_addr;
   assign imem_wdata_o  = r_wdata;
   assign cpu_run_o     = (r_state == S_RUN);
   assign load_done_o   = r_done;
   assign load_err_o    = r_err;
   assign instr_count_o = r_count;

endmodule

// File: tb/tb_instr_boot_loader.sv
module tb_instr_boot_loader;

   logic        clk_i = 1'b0;
   logic        reset = 1'b0;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  instr_i = 8'h00;
   logic        imem_we_o;
   logic [5:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   logic        cpu_run_o;
   logic        load_done_o;
   logic        load_err_o;
   logic [6:0]  instr_count_o;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [37:0] exp_q[$];

   instr_boot_loader dut (
      .clk_i         (clk_i),
      .reset         (reset),
      .byte_valid_i  (byte_valid_i),
      .instr_i       (instr_i),
      .imem_we_o     (imem_we_o),
      .imem_addr_o   (imem_addr_o),
      .imem_wdata_o  (imem_wdata_o),
      .cpu_run_o     (cpu_run_o),
      .load_done_o   (load_done_o),
      .load_err_o    (load_err_o),
      .instr_count_o (instr_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write monitor / scoreboard consumer
   always @(negedge clk_i) begin
      if (load_done_o) done_cnt++;
      if (imem_we_o) begin
         if (exp_q.size() == 0) begin
            check_val("we_unexpected", 64'(imem_we_o), 64'd0);
         end else begin
            logic [37:0] e;
            e = exp_q.pop_front();
            check_val("we_addr", 64'(imem_addr_o), 64'(e[37:32]));
            check_val("we_data", 64'(imem_wdata_o), 64'(e[31:0]));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(posedge clk_i);
         #1;
      end
      byte_valid_i = 1'b1;
      instr_i      = b;
      @(posedge clk_i);
      #1;
      byte_valid_i = 1'b0;
      instr_i      = 8'h00;
   endtask

   task automatic send_frame(input logic [31:0] words[$], input logic [7:0] trailer,
                             input int max_gap, input bit skip_start);
      if (!skip_start) send_byte(8'hFE, $urandom_range(max_gap, 0));
      send_byte(8'(words.size()), $urandom_range(max_gap, 0));
      for (int i = 0; i < words.size(); i++) begin
         exp_q.push_back({6'(i), words[i]});
         for (int k = 3; k >= 0; k--)
            send_byte(words[i][k*8 +: 8], $urandom_range(max_gap, 0));
      end
      send_byte(trailer, $urandom_range(max_gap, 0));
   endtask

   task automatic settle();
      repeat (2) @(negedge clk_i);
      #1;
   endtask

   task automatic check_clean(input string tag, input int d0, input int cnt);
      settle();
      check_val({tag, "_run"}, 64'(cpu_run_o), 64'd1);
      check_val({tag, "_err"}, 64'(load_err_o), 64'd0);
      check_val({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
      check_val({tag, "_cnt"}, 64'(instr_count_o), 64'(cnt));
      check_val({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_err(input string tag, input int d0);
      settle();
      check_val({tag, "_err"}, 64'(load_err_o), 64'd1);
      check_val({tag, "_run"}, 64'(cpu_run_o), 64'd0);
      check_val({tag, "_done"}, 64'(done_cnt - d0), 64'd0);
      check_val({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_we"}, 64'(imem_we_o), 64'd0);
      check_val({tag, "_addr"}, 64'(imem_addr_o), 64'd0);
      check_val({tag, "_wdata"}, 64'(imem_wdata_o), 64'd0);
      check_val({tag, "_run"}, 64'(cpu_run_o), 64'd0);
      check_val({tag, "_done"}, 64'(load_done_o), 64'd0);
      check_val({tag, "_err"}, 64'(load_err_o), 64'd0);
      check_val({tag, "_cnt"}, 64'(instr_count_o), 64'd0);
   endtask

   initial begin
      logic [31:0] wq[$];
      logic [31:0] two_words[$];
      logic [7:0]  ib;
      int d0;

      two_words = '{32'h00500093, 32'h00A00113};

      repeat (3) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      reset = 1'b1;
      @(posedge clk_i);
      #1;

      // clean load with leading padding
      send_byte(8'h00, 0);
      d0 = done_cnt;
      send_frame(two_words, 8'hFF, 0, 1'b0);
      check_clean("clean", d0, 2);

      // token values as payload data; also a reload from RUN
      wq = '{32'hFFFEFFFE};
      d0 = done_cnt;
      send_frame(wq, 8'hFF, 0, 1'b0);
      check_clean("tokdata", d0, 1);

      // reload: FE in RUN drops cpu_run_o the next cycle
      send_byte(8'hFE, 0);
      @(negedge clk_i);
      check_val("reload_run_drop", 64'(cpu_run_o), 64'd0);
      wq = '{32'h12345678};
      d0 = done_cnt;
      send_frame(wq, 8'hFF, 0, 1'b1);
      check_clean("reload", d0, 1);

      // length 0
      d0 = done_cnt;
      send_byte(8'hFE, 0);
      send_byte(8'h00, 0);
      check_err("len0", d0);
      d0 = done_cnt;
      send_frame(two_words, 8'hFF, 0, 1'b0);
      check_clean("len0_recover", d0, 2);

      // length 65
      d0 = done_cnt;
      send_byte(8'hFE, 0);
      send_byte(8'h41, 0);
      send_byte(8'h11, 0);
      check_err("len65", d0);
      send_byte(8'hFE, 0);
      @(negedge clk_i);
      check_val("len65_errclr", 64'(load_err_o), 64'd0);
      d0 = done_cnt;
      send_frame(two_words, 8'hFF, 0, 1'b1);
      check_clean("len65_recover", d0, 2);

      // bad trailer: word still written
      wq = '{32'hCAFEF00D};
      d0 = done_cnt;
      send_frame(wq, 8'h00, 0, 1'b0);
      check_err("trailer", d0);
      check_val("trailer_cnt", 64'(instr_count_o), 64'd1);
      d0 = done_cnt;
      send_frame(two_words, 8'hFF, 0, 1'b0);
      check_clean("trailer_recover", d0, 2);

      // random valid gaps
      for (int r = 0; r < 3; r++) begin
         d0 = done_cnt;
         send_frame(two_words, 8'hFF, 3, 1'b0);
         check_clean("gaps", d0, 2);
      end

      // reset mid-frame after the second payload byte
      send_byte(8'hFE, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      reset = 1'b0;
      #2;
      check_all_zero("midrst");
      repeat (3) @(negedge clk_i);
      check_all_zero("midrst_hold");
      @(posedge clk_i);
      #1;
      reset = 1'b1;
      @(posedge clk_i);
      #1;
      d0 = done_cnt;
      send_frame(two_words, 8'hFF, 0, 1'b0);
      check_clean("postrst", d0, 2);

      // full depth
      wq = {};
      for (int i = 0; i < 64; i++) begin
         ib = 8'(i);
         wq.push_back({4{ib}});
      end
      d0 = done_cnt;
      send_frame(wq, 8'hFF, 0, 1'b0);
      check_clean("full", d0, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
